// File: rtl/checkpoint_types.sv
// rtl/checkpoint_types.sv - branch checkpoint snapshot types
package checkpoint_types;

  typedef ooop_types::fl_ptr_t fl_ckpt_t;

endpackage

// File: rtl/ooop_types.sv
// rtl/ooop_types.sv - shared core widths and free-list pointer type
package ooop_types;

  localparam int N_PREGS   = 64;
  localparam int N_ARCH    = 32;
  localparam int PREG_W    = $clog2(N_PREGS);
  localparam int ROB_DEPTH = 32;
  localparam int ROB_W     = $clog2(ROB_DEPTH);
  localparam int FL_DEPTH  = N_PREGS - N_ARCH;
  localparam int FL_PTR_W  = $clog2(FL_DEPTH);

  // Extra MSB is the wrap bit so full and empty are distinguishable.
  typedef logic [FL_PTR_W:0] fl_ptr_t;

endpackage

// File: rtl/free_list.sv
// rtl/free_list.sv - physical-register free list with per-ROB-tag head snapshots
// Optional FREE_LIST_CHECK_EN: sticky error_o on overflow push or recover to an unwritten slot.
module free_list
  import ooop_types::*;
  import checkpoint_types::*;
#(
  parameter int N_PREGS  = ooop_types::N_PREGS,
  parameter int N_ARCH   = ooop_types::N_ARCH,
  parameter int FL_DEPTH = N_PREGS - N_ARCH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                recover_i,
  input  logic [ROB_W-1:0]    recover_tag_i,
  input  logic                checkpoint_take_i,
  input  logic [ROB_W-1:0]    checkpoint_tag_i,
  input  logic                alloc_i,
  output logic                alloc_ready_o,
  output logic [PREG_W-1:0]   alloc_preg_o,
  input  logic                free_req_i,
  input  logic [PREG_W-1:0]   free_preg_i,
  output logic [FL_PTR_W:0]   free_count_o,
  output logic                error_o
);

  localparam fl_ptr_t FL_FULL = fl_ptr_t'(FL_DEPTH);

  fl_ptr_t           head_q, head_d, tail_q, tail_d, chead_q, chead_d;
  fl_ptr_t           count;
  logic [PREG_W-1:0] mem_q [FL_DEPTH];
  fl_ckpt_t          ckpt_q [ROB_DEPTH];
  logic              push, pop, ckpt_we;

  assign count         = tail_q - head_q;
  assign alloc_ready_o = (count != '0);
  assign alloc_preg_o  = mem_q[head_q[FL_PTR_W-1:0]];
  assign free_count_o  = count;

  assign pop     = alloc_i && alloc_ready_o && !flush_i && !recover_i;
  assign ckpt_we = checkpoint_take_i && !flush_i && !recover_i;

`ifdef FREE_LIST_CHECK_EN
  logic                 full;
  logic                 error_q;
  logic [ROB_DEPTH-1:0] ckpt_vld_q;

  assign full    = (count == FL_FULL);
  assign push    = free_req_i && (free_preg_i != '0) && !full;
  assign error_o = error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q    <= 1'b0;
      ckpt_vld_q <= '0;
    end else begin
      if (ckpt_we) ckpt_vld_q[checkpoint_tag_i] <= 1'b1;
      if ((free_req_i && (free_preg_i != '0) && full) ||
          (recover_i && !flush_i && !ckpt_vld_q[recover_tag_i]))
        error_q <= 1'b1;
    end
  end
`else
  assign push    = free_req_i && (free_preg_i != '0);
  assign error_o = 1'b0;
`endif

  // Every commit that frees a preg also retires one allocation, so chead moves with tail.
  always_comb begin
    tail_d  = tail_q + fl_ptr_t'(push);
    chead_d = chead_q + fl_ptr_t'(push);
    head_d  = head_q + fl_ptr_t'(pop);
    if (flush_i)        head_d = chead_d;
    else if (recover_i) head_d = ckpt_q[recover_tag_i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= FL_FULL;
      for (int i = 0; i < FL_DEPTH; i++) mem_q[i] <= PREG_W'(N_ARCH + i);
      for (int i = 0; i < ROB_DEPTH; i++) ckpt_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      chead_q <= chead_d;
      if (push)    mem_q[tail_q[FL_PTR_W-1:0]] <= free_preg_i;
      if (ckpt_we) ckpt_q[checkpoint_tag_i] <= head_d;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - self-checking bench for free_list (scoreboarded pops)
module tb_free_list;

  localparam int PREG_W = 6;
  localparam int ROB_W  = 5;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush_i = 1'b0;
  logic              recover_i = 1'b0;
  logic [ROB_W-1:0]  recover_tag_i = '0;
  logic              checkpoint_take_i = 1'b0;
  logic [ROB_W-1:0]  checkpoint_tag_i = '0;
  logic              alloc_i = 1'b0;
  logic              alloc_ready_o;
  logic [PREG_W-1:0] alloc_preg_o;
  logic              free_req_i = 1'b0;
  logic [PREG_W-1:0] free_preg_i = '0;
  logic [CNT_W-1:0]  free_count_o;
  logic              error_o;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  free_list dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .recover_i(recover_i),
    .recover_tag_i(recover_tag_i), .checkpoint_take_i(checkpoint_take_i),
    .checkpoint_tag_i(checkpoint_tag_i), .alloc_i(alloc_i),
    .alloc_ready_o(alloc_ready_o), .alloc_preg_o(alloc_preg_o),
    .free_req_i(free_req_i), .free_preg_i(free_preg_i),
    .free_count_o(free_count_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 32; i < 64; i++) exp_q.push_back(i);
  endtask

  task automatic pop_one(input string tag);
    int e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty, dut gave %0d", tag, alloc_preg_o);
    end else begin
      e = exp_q.pop_front();
      if (alloc_ready_o !== 1'b1 || alloc_preg_o !== PREG_W'(e)) begin
        miscompares++;
        $display("FAIL %s: ready=%0b preg=%0d, expected ready=1 preg=%0d", tag, alloc_ready_o, alloc_preg_o, e);
      end
    end
    alloc_i = 1'b1;
    step();
    alloc_i = 1'b0;
    checkpoint_take_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (alloc_ready_o !== 1'b1 || alloc_preg_o !== 6'd32 || free_count_o !== 6'd32 || error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: ready=%0b preg=%0d count=%0d err=%0b, expected 1/32/32/0",
               alloc_ready_o, alloc_preg_o, free_count_o, error_o);
    end
  endtask

  task automatic test_drain_and_refill();
    do_reset();
    for (int i = 0; i < 32; i++) pop_one("drain");
    vectors++;
    if (alloc_ready_o !== 1'b0 || free_count_o !== 6'd0) begin
      miscompares++;
      $display("FAIL empty: ready=%0b count=%0d, expected 0/0", alloc_ready_o, free_count_o);
    end
    alloc_i = 1'b1;
    step();
    alloc_i = 1'b0;
    vectors++;
    if (alloc_ready_o !== 1'b0 || free_count_o !== 6'd0 || alloc_preg_o !== 6'd32) begin
      miscompares++;
      $display("FAIL alloc_empty: ready=%0b count=%0d preg=%0d, expected 0/0/32", alloc_ready_o, free_count_o, alloc_preg_o);
    end
    free_req_i = 1'b1;
    free_preg_i = 6'd40;
    #1;
    vectors++;
    if (alloc_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL no_bypass: ready=%0b, expected 0", alloc_ready_o);
    end
    step();
    free_req_i = 1'b0;
    exp_q.push_back(40);
    vectors++;
    if (free_count_o !== 6'd1) begin
      miscompares++;
      $display("FAIL refill_count: count=%0d, expected 1", free_count_o);
    end
    // Pop 40 while freeing 41: occupancy must hold at 1.
    free_req_i = 1'b1;
    free_preg_i = 6'd41;
    exp_q.push_back(41);
    pop_one("refill");
    free_req_i = 1'b0;
    vectors++;
    if (free_count_o !== 6'd1) begin
      miscompares++;
      $display("FAIL pop_push_count: count=%0d, expected 1", free_count_o);
    end
    pop_one("refill2");
    // Free of preg 0 is ignored.
    free_req_i = 1'b1;
    free_preg_i = 6'd0;
    step();
    free_req_i = 1'b0;
    vectors++;
    if (free_count_o !== 6'd0) begin
      miscompares++;
      $display("FAIL free_zero: count=%0d, expected 0", free_count_o);
    end
  endtask

  task automatic test_recover();
    do_reset();
    pop_one("rec_a");
    pop_one("rec_b");
    checkpoint_take_i = 1'b1;
    checkpoint_tag_i = 5'd3;
    step();
    checkpoint_take_i = 1'b0;
    for (int i = 0; i < 3; i++) pop_one("rec_c");
    recover_i = 1'b1;
    recover_tag_i = 5'd3;
    alloc_i = 1'b1;
    step();
    recover_i = 1'b0;
    alloc_i = 1'b0;
    exp_q.delete();
    for (int i = 34; i < 64; i++) exp_q.push_back(i);
    vectors++;
    if (alloc_preg_o !== 6'd34 || free_count_o !== 6'd30) begin
      miscompares++;
      $display("FAIL recover3: preg=%0d count=%0d, expected 34/30", alloc_preg_o, free_count_o);
    end
    // Checkpoint with same-cycle pop snapshots the post-pop head.
    checkpoint_take_i = 1'b1;
    checkpoint_tag_i = 5'd5;
    pop_one("rec_d");
    pop_one("rec_e");
    pop_one("rec_f");
    recover_i = 1'b1;
    recover_tag_i = 5'd5;
    step();
    recover_i = 1'b0;
    vectors++;
    if (alloc_preg_o !== 6'd35 || free_count_o !== 6'd29) begin
      miscompares++;
      $display("FAIL recover5: preg=%0d count=%0d, expected 35/29", alloc_preg_o, free_count_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) pop_one("fl_pop");
    free_req_i = 1'b1;
    free_preg_i = 6'd5;
    step();
    free_req_i = 1'b0;
    flush_i = 1'b1;
    recover_i = 1'b1;
    recover_tag_i = 5'd0;
    alloc_i = 1'b1;
    step();
    flush_i = 1'b0;
    recover_i = 1'b0;
    alloc_i = 1'b0;
    vectors++;
    if (alloc_preg_o !== 6'd33 || free_count_o !== 6'd32) begin
      miscompares++;
      $display("FAIL flush: preg=%0d count=%0d, expected 33/32", alloc_preg_o, free_count_o);
    end
    exp_q.delete();
    for (int i = 33; i < 64; i++) exp_q.push_back(i);
    exp_q.push_back(5);
    for (int i = 0; i < 32; i++) pop_one("fl_drain");
    vectors++;
    if (alloc_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_drain_empty: ready=%0b, expected 0", alloc_ready_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) pop_one("ar_pop");
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (alloc_preg_o !== 6'd32 || free_count_o !== 6'd32 || alloc_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: preg=%0d count=%0d ready=%0b, expected 32/32/1", alloc_preg_o, free_count_o, alloc_ready_o);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_full_push();
    do_reset();
    free_req_i = 1'b1;
    free_preg_i = 6'd7;
    step();
    free_req_i = 1'b0;
`ifdef FREE_LIST_CHECK_EN
    vectors++;
    if (error_o !== 1'b1 || free_count_o !== 6'd32) begin
      miscompares++;
      $display("FAIL overflow: err=%0b count=%0d, expected 1/32", error_o, free_count_o);
    end
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if (error_o !== 1'b1) begin
      miscompares++;
      $display("FAIL sticky: err=%0b, expected 1", error_o);
    end
    do_reset();
    recover_i = 1'b1;
    recover_tag_i = 5'd9;
    step();
    recover_i = 1'b0;
    vectors++;
    if (error_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_slot: err=%0b, expected 1", error_o);
    end
`else
    vectors++;
    if (error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL err_tied: err=%0b, expected 0", error_o);
    end
`endif
    do_reset();
    vectors++;
    if (error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: err=%0b, expected 0", error_o);
    end
  endtask

  initial begin
    test_reset();
    test_drain_and_refill();
    test_recover();
    test_flush();
    test_async_reset();
    test_full_push();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
